// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-stage observation inputs and hazard-control outputs
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             id_valid, id_uses_rs1, id_uses_rs2;
  logic [REG_W-1:0] id_rs1, id_rs2;
  logic             ex_valid, ex_reg_write, ex_mem_read, ex_branch_taken;
  logic [REG_W-1:0] ex_rd;
  logic             mem_valid, mem_reg_write, mem_mem_read, mem_req;
  logic [REG_W-1:0] mem_rd;
  logic             dmem_ready;
  logic             wb_valid, wb_reg_write;
  logic [REG_W-1:0] wb_rd;
  logic             pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic             if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output id_valid, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2,
           ex_valid, ex_reg_write, ex_mem_read, ex_branch_taken, ex_rd,
           mem_valid, mem_reg_write, mem_mem_read, mem_req, mem_rd, dmem_ready,
           wb_valid, wb_reg_write, wb_rd,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, mem_wb_flush, fwd_a, fwd_b,
           mem_timeout, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_valid, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2,
           ex_valid, ex_reg_write, ex_mem_read, ex_branch_taken, ex_rd,
           mem_valid, mem_reg_write, mem_mem_read, mem_req, mem_rd, dmem_ready,
           wb_valid, wb_reg_write, wb_rd,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, mem_wb_flush, fwd_a, fwd_b,
           mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding control with memory-wait watchdog and perf counters
module pipeline_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] TO = WC_W'(TIMEOUT);
  state_e state_q, state_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic req_stall, mem_stall, redirect, load_use, ex_w, mem_w;
  logic pc_stall, id_ex_stall, if_id_flush, id_ex_flush;
  logic unused_wb;
  assign unused_wb = ^{bus.wb_valid, bus.wb_reg_write, bus.wb_rd, bus.mem_mem_read};
  function automatic logic [1:0] sel(input logic uses, input logic [REG_W-1:0] r,
                                     input logic exw, input logic [REG_W-1:0] exrd,
                                     input logic memw, input logic [REG_W-1:0] memrd);
    return (!uses || r == '0) ? 2'b00 : (exw && exrd == r) ? 2'b01 :
           (memw && memrd == r) ? 2'b10 : 2'b00;
  endfunction
  always_comb begin
    req_stall = bus.mem_valid && bus.mem_req && !bus.dmem_ready;
    mem_stall = req_stall || state_q == ERROR;
    redirect  = bus.ex_branch_taken && bus.ex_valid;
    load_use  = bus.id_valid && bus.ex_valid && bus.ex_mem_read && bus.ex_rd != '0 &&
                ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) ||
                 (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
    pc_stall    = !reset && (mem_stall || (!redirect && load_use));
    id_ex_stall = !reset && mem_stall;
    if_id_flush = !reset && !mem_stall && redirect;
    id_ex_flush = !reset && !mem_stall && (redirect || load_use);
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? RUN : state_d;
    wcnt_q  <= reset ? '0 : wcnt_d;
  end
  always_comb begin
    wcnt_inc = wcnt_q + WC_W'(1);
    state_d  = state_q == RUN ? (req_stall ? MEM_WAIT : RUN) :
               state_q == MEM_WAIT ? (bus.dmem_ready ? RUN : (wcnt_inc == TO ? ERROR : MEM_WAIT)) :
               ERROR;
    wcnt_d   = state_q == RUN ? (req_stall ? WC_W'(1) : '0) :
               state_q == MEM_WAIT ? (bus.dmem_ready ? '0 : wcnt_inc) : wcnt_q;
  end
  always_comb begin
    bus.pc_stall     = pc_stall;
    bus.if_id_stall  = pc_stall;
    bus.id_ex_stall  = id_ex_stall;
    bus.ex_mem_stall = id_ex_stall;
    bus.mem_wb_flush = id_ex_stall;
    bus.if_id_flush  = if_id_flush;
    bus.id_ex_flush  = id_ex_flush;
    bus.mem_timeout  = state_q == ERROR;
    bus.fwd_a        = fwd_a_q;
    bus.fwd_b        = fwd_b_q;
    bus.stall_cnt    = stall_cnt_q;
    bus.flush_cnt    = flush_cnt_q;
  end
  // EX forwarding only from non-load producers; a load in EX is covered by the load-use bubble
  always_comb begin
    ex_w  = bus.ex_valid && bus.ex_reg_write && !bus.ex_mem_read;
    mem_w = bus.mem_valid && bus.mem_reg_write;
    fwd_a_d = id_ex_flush ? 2'b00 : id_ex_stall ? fwd_a_q :
              sel(bus.id_uses_rs1, bus.id_rs1, ex_w, bus.ex_rd, mem_w, bus.mem_rd);
    fwd_b_d = id_ex_flush ? 2'b00 : id_ex_stall ? fwd_b_q :
              sel(bus.id_uses_rs2, bus.id_rs2, ex_w, bus.ex_rd, mem_w, bus.mem_rd);
    stall_cnt_d = (pc_stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = ((if_id_flush || id_ex_flush) && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  always_ff @(posedge clk) begin
    fwd_a_q     <= reset ? 2'b00 : fwd_a_d;
    fwd_b_q     <= reset ? 2'b00 : fwd_b_d;
    stall_cnt_q <= reset ? '0 : stall_cnt_d;
    flush_cnt_q <= reset ? '0 : flush_cnt_d;
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard control with TIMEOUT=4, CNT_W=4
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(4)) bus ();
  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(4), .TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.id_valid = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.ex_valid = 0; bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_branch_taken = 0; bus.ex_rd = 0;
    bus.mem_valid = 0; bus.mem_reg_write = 0; bus.mem_mem_read = 0; bus.mem_req = 0; bus.mem_rd = 0;
    bus.dmem_ready = 1; bus.wb_valid = 0; bus.wb_reg_write = 0; bus.wb_rd = 0;
  endtask
  task automatic load_use_vec(input logic [4:0] rd);
    idle();
    bus.ex_valid = 1; bus.ex_reg_write = 1; bus.ex_mem_read = 1; bus.ex_rd = rd;
    bus.id_valid = 1; bus.id_uses_rs2 = 1; bus.id_rs2 = rd;
  endtask
  task automatic mem_wait_vec();
    idle();
    bus.mem_valid = 1; bus.mem_req = 1; bus.dmem_ready = 0;
  endtask
  initial begin
    load_use_vec(5'd7);
    #1;
    chk("reset_pc_stall", bus.pc_stall, 0);
    chk("reset_id_ex_flush", bus.id_ex_flush, 0);
    tick();
    tick();
    chk("reset_fwd_b", bus.fwd_b, 0);
    chk("reset_stall_cnt", bus.stall_cnt, 0);
    chk("reset_flush_cnt", bus.flush_cnt, 0);
    chk("reset_timeout", bus.mem_timeout, 0);
    idle();
    reset = 0;
    tick();
    // ALU producer in EX
    idle();
    bus.ex_valid = 1; bus.ex_reg_write = 1; bus.ex_rd = 5;
    bus.id_valid = 1; bus.id_uses_rs1 = 1; bus.id_rs1 = 5;
    #1;
    chk("alu_ex_no_stall", bus.pc_stall, 0);
    tick();
    chk("alu_ex_fwd_a", bus.fwd_a, 2'b01);
    chk("alu_ex_fwd_b", bus.fwd_b, 2'b00);
    // producer in MEM
    idle();
    bus.mem_valid = 1; bus.mem_reg_write = 1; bus.mem_rd = 5;
    bus.id_valid = 1; bus.id_uses_rs1 = 1; bus.id_rs1 = 5;
    tick();
    chk("alu_mem_fwd_a", bus.fwd_a, 2'b10);
    // EX beats MEM; uses_rs1=0 gates rs1
    idle();
    bus.ex_valid = 1; bus.ex_reg_write = 1; bus.ex_rd = 5;
    bus.mem_valid = 1; bus.mem_reg_write = 1; bus.mem_rd = 5;
    bus.id_valid = 1; bus.id_rs1 = 5; bus.id_uses_rs2 = 1; bus.id_rs2 = 5;
    tick();
    chk("prio_fwd_b", bus.fwd_b, 2'b01);
    chk("nouse_fwd_a", bus.fwd_a, 2'b00);
    // x0 never forwards
    idle();
    bus.ex_valid = 1; bus.ex_reg_write = 1; bus.ex_rd = 0;
    bus.id_valid = 1; bus.id_uses_rs1 = 1; bus.id_rs1 = 0;
    tick();
    chk("x0_fwd_a", bus.fwd_a, 2'b00);
    // load-use on x7 via rs2
    load_use_vec(5'd7);
    #1;
    chk("lu_pc_stall", bus.pc_stall, 1);
    chk("lu_if_id_stall", bus.if_id_stall, 1);
    chk("lu_id_ex_flush", bus.id_ex_flush, 1);
    chk("lu_if_id_flush", bus.if_id_flush, 0);
    chk("lu_id_ex_stall", bus.id_ex_stall, 0);
    tick();
    chk("lu_bubble_fwd_b", bus.fwd_b, 2'b00);
    chk("lu_stall_cnt", bus.stall_cnt, 1);
    chk("lu_flush_cnt", bus.flush_cnt, 1);
    idle();
    bus.mem_valid = 1; bus.mem_reg_write = 1; bus.mem_mem_read = 1; bus.mem_rd = 7;
    bus.id_valid = 1; bus.id_uses_rs2 = 1; bus.id_rs2 = 7;
    #1;
    chk("lu_release_pc_stall", bus.pc_stall, 0);
    tick();
    chk("lu_fwd_b_wb", bus.fwd_b, 2'b10);
    chk("lu_stall_cnt_once", bus.stall_cnt, 1);
    // load to x0: no hazard
    load_use_vec(5'd0);
    #1;
    chk("lu_x0_pc_stall", bus.pc_stall, 0);
    chk("lu_x0_id_ex_flush", bus.id_ex_flush, 0);
    tick();
    chk("lu_x0_flush_cnt", bus.flush_cnt, 1);
    // redirect beats load-use
    load_use_vec(5'd7);
    bus.ex_branch_taken = 1;
    #1;
    chk("br_if_id_flush", bus.if_id_flush, 1);
    chk("br_id_ex_flush", bus.id_ex_flush, 1);
    chk("br_pc_stall", bus.pc_stall, 0);
    tick();
    chk("br_flush_cnt", bus.flush_cnt, 2);
    chk("br_stall_cnt", bus.stall_cnt, 1);
    // 3-cycle memory wait with a pending redirect
    mem_wait_vec();
    bus.ex_valid = 1; bus.ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_pc_stall", bus.pc_stall, 1);
      chk("mw_ex_mem_stall", bus.ex_mem_stall, 1);
      chk("mw_mem_wb_flush", bus.mem_wb_flush, 1);
      chk("mw_if_id_flush", bus.if_id_flush, 0);
      tick();
    end
    bus.dmem_ready = 1;
    #1;
    chk("mw_done_pc_stall", bus.pc_stall, 0);
    chk("mw_done_if_id_flush", bus.if_id_flush, 1);
    chk("mw_done_mem_wb_flush", bus.mem_wb_flush, 0);
    tick();
    chk("mw_stall_cnt", bus.stall_cnt, 4);
    chk("mw_flush_cnt", bus.flush_cnt, 3);
    chk("mw_timeout", bus.mem_timeout, 0);
    // ready in the same cycle as the request
    idle();
    bus.mem_valid = 1; bus.mem_req = 1;
    #1;
    chk("rdy_same_pc_stall", bus.pc_stall, 0);
    tick();
    // watchdog: 4 wait cycles then ERROR
    mem_wait_vec();
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("to_pc_stall", bus.pc_stall, 1);
      tick();
      chk("to_mem_timeout", bus.mem_timeout, (i == 4) ? 1 : 0);
    end
    load_use_vec(5'd7);
    bus.ex_branch_taken = 1;
    #1;
    chk("err_pc_stall", bus.pc_stall, 1);
    chk("err_mem_wb_flush", bus.mem_wb_flush, 1);
    chk("err_if_id_flush", bus.if_id_flush, 0);
    tick();
    chk("err_sticky", bus.mem_timeout, 1);
    chk("err_stall_cnt", bus.stall_cnt, 9);
    reset = 1;
    #1;
    chk("rst_err_pc_stall", bus.pc_stall, 0);
    tick();
    reset = 0;
    idle();
    #1;
    chk("rst_err_timeout", bus.mem_timeout, 0);
    chk("rst_err_pc_stall_after", bus.pc_stall, 0);
    chk("rst_err_stall_cnt", bus.stall_cnt, 0);
    chk("rst_err_flush_cnt", bus.flush_cnt, 0);
    chk("rst_err_fwd_a", bus.fwd_a, 0);
    // reset mid-wait clears the watchdog count
    mem_wait_vec();
    tick(); tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_midwait_timeout", bus.mem_timeout, 0);
    chk("rst_midwait_stall_cnt", bus.stall_cnt, 3);
    idle();
    reset = 1;
    tick();
    reset = 0;
    // counter saturation at 4 bits
    load_use_vec(5'd9);
    for (int i = 0; i < 15; i++) tick();
    chk("sat_stall_cnt_15", bus.stall_cnt, 15);
    chk("sat_flush_cnt_15", bus.flush_cnt, 15);
    tick();
    chk("sat_stall_cnt_hold", bus.stall_cnt, 15);
    chk("sat_flush_cnt_hold", bus.flush_cnt, 15);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It observes register usage and valid bits in ID/EX/MEM/WB plus data-memory readiness, and drives per-cycle stall, flush and operand-forwarding selects into the stage registers. It also runs a memory-wait state machine with a timeout watchdog, and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- REG_W, 5, register index width
- CNT_W, 32, performance counter width
- TIMEOUT, 64, max consecutive MEM_WAIT cycles before error (≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_valid, id_uses_rs1, id_uses_rs2  in  1 each  ID instruction valid / reads rs1 / reads rs2
- id_rs1, id_rs2  in  REG_W  ID source registers
- ex_valid, ex_reg_write, ex_mem_read  in  1 each  EX valid / writes rd / is load
- ex_rd  in  REG_W  EX destination
- ex_branch_taken  in  1  branch/jump resolved taken in EX (redirect)
- mem_valid, mem_reg_write, mem_mem_read, mem_req  in  1 each  MEM valid / writes rd / is load / accesses data memory
- mem_rd  in  REG_W  MEM destination
- dmem_ready  in  1  data memory completes access this cycle
- wb_valid, wb_reg_write  in  1 each;  wb_rd  in  REG_W
- pc_stall, if_id_stall  out  1  hold PC / IF-ID register
- id_ex_stall, ex_mem_stall  out  1  hold ID-EX / EX-MEM register
- if_id_flush, id_ex_flush  out  1  load bubble into IF-ID / ID-EX
- mem_wb_flush  out  1  load bubble into MEM-WB
- fwd_a, fwd_b  out  2  operand select for rs1/rs2 of EX: 00 regfile, 01 EX-MEM, 10 MEM-WB
- mem_timeout  out  1  sticky error
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- Match rule: source r "hits" stage S iff S_valid && S_reg_write && S_rd == r && r != 0. x0 never hits.
- Forwarding uses ID-EX sources, registered: fwd_a/fwd_b are computed from id_rs1/id_rs2 against ex_* and mem_* and latched into a select register when ID-EX advances, so they are aligned with the instruction in EX. Select register is unchanged when id_ex_stall; 00 when id_ex_flush.
- Select priority: an EX hit (non-load) gives 01. Otherwise a MEM hit gives 10. Otherwise 00. If uses_rsN=0, the select is 00.
- mem_stall = mem_valid && mem_req && !dmem_ready, or state == ERROR.
- load_use = id_valid && ex_valid && ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)).
- Priority is mem_stall > redirect > load_use:
  - mem_stall: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush = 1; all other flushes 0. A redirect or load_use is deferred and re-evaluated when the stall releases, because the inputs are held.
  - redirect (ex_branch_taken && ex_valid): if_id_flush = id_ex_flush = 1; no stalls.
  - load_use: pc_stall = if_id_stall = 1; id_ex_flush = 1 (one bubble).
  - otherwise all controls are 0.
- FSM states are RUN, MEM_WAIT, ERROR.
  - RUN → MEM_WAIT when mem_valid && mem_req && !dmem_ready. The wait counter loads 1.
  - MEM_WAIT → RUN when dmem_ready.
  - MEM_WAIT: otherwise the counter increments. Go to ERROR when the counter reaches TIMEOUT.
  - ERROR is sticky until reset: mem_timeout = 1, and the full freeze above persists.
- Counters saturate at all-ones, never wrap.
  - stall_cnt increments each cycle pc_stall = 1.
  - flush_cnt increments each cycle if_id_flush or id_ex_flush = 1 (at most +1 per cycle).

## Timing
- Stall and flush outputs are combinational from current inputs and state: zero-cycle latency.
- fwd_a/fwd_b, state, wait counter, mem_timeout and counters are registered; they update on the rising edge.
- Reset (while high, and the cycle after deassertion begins clean):
  - all stall/flush outputs forced 0
  - fwd_a = fwd_b = 00
  - state RUN, wait counter 0, mem_timeout 0
  - stall_cnt = flush_cnt = 0
- Reset mid-MEM_WAIT or in ERROR returns to RUN on that edge; pending hazards are dropped.
- A load-use costs exactly 1 bubble. The consumer then sees fwd = 10 (WB forward) in EX.
- A redirect costs exactly 2 bubbles.
- dmem_ready in the same cycle mem_req first appears: no stall, and the FSM stays RUN.
- ERROR is entered on the edge ending the TIMEOUT-th consecutive wait cycle.

## Test plan
- Back-to-back ALU dependency (EX writes x5, ID reads x5 as rs1) → fwd_a = 01 next cycle, no stall. Repeat with the producer one stage further → fwd_a = 10.
- Load x7 in EX, ID uses x7 as rs2 → pc_stall = if_id_stall = id_ex_flush = 1 for exactly 1 cycle; next cycle fwd_b = 10; stall_cnt = 1, flush_cnt = 1. Same with rd = x0 → no stall.
- ex_branch_taken = 1 with a simultaneous load_use → if_id_flush = id_ex_flush = 1, pc_stall = 0; flush_cnt += 1.
- mem_req with dmem_ready low for 3 cycles while ex_branch_taken = 1 → 3 cycles of full freeze plus mem_wb_flush; FSM RUN→MEM_WAIT→RUN; redirect flush in the cycle dmem_ready = 1.
- TIMEOUT = 4, dmem_ready held low → mem_timeout rises after the 4th wait cycle and stays 1 with the freeze held. reset = 1 for 1 cycle → all outputs 0, state RUN, counters 0.
- Force stall_cnt near saturation with CNT_W = 4 → 15 stall cycles give 15, the 16th keeps 15.
